// File: rtl/sprite_mem_scheduler.sv
// Arbitrates the shared sprite row memory between the scan-line prefetcher and a host writer.
// Optional SPRITE_MIRROR_EN: captured rows are stored bit-reversed (horizontal mirror).
module sprite_mem_scheduler #(
    parameter int ROWS      = 64,
    parameter int AW        = 6,
    parameter int DW        = 64,
    parameter int SPRITE_Y0 = 210,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic [9:0]    cur_y,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] row_data,
    output logic          row_valid,
    output logic          fetch_miss
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        CAPTURE
    } state_t;

    localparam logic [1:0]  WAIT_INIT = 2'(RD_LAT - 1);
    localparam logic [9:0]  Y_LO      = 10'(SPRITE_Y0);
    localparam logic [10:0] Y_HI      = 11'(SPRITE_Y0 + ROWS);
    localparam logic [AW:0] ROWS_L    = (AW + 1)'(ROWS);

    state_t        state, state_nxt;
    logic          fetch_pend;
    logic [AW-1:0] fetch_row;
    logic [1:0]    wait_cnt;
    logic [DW-1:0] shadow;
    logic          shadow_valid;

    logic [9:0]    ny;
    logic          ny_in_range;
    logic [AW-1:0] ny_row;
    logic          abort;
    logic          host_addr_ok;

    function automatic logic [DW-1:0] capture_fmt(input logic [DW-1:0] d);
`ifdef SPRITE_MIRROR_EN
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = d[DW-1-i];
        end
        return r;
`else
        return d;
`endif
    endfunction

    // Next displayed line wraps from the last line of the frame back to line 1.
    assign ny           = (cur_y == 10'd524) ? 10'd1 : cur_y + 10'd1;
    assign ny_in_range  = (ny >= Y_LO) && ({1'b0, ny} < Y_HI);
    assign ny_row       = AW'(ny - Y_LO);
    assign abort        = line_start && ((state != IDLE) || fetch_pend);
    assign host_addr_ok = ({1'b0, host_addr} < ROWS_L);

    always_comb begin
        state_nxt  = state;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        host_ready = rst && (state == IDLE) && !fetch_pend && !line_start;

        case (state)
            IDLE: begin
                if (fetch_pend) begin
                    state_nxt = RD_ISSUE;
                end else if (host_valid && host_ready && host_addr_ok) begin
                    mem_we    = 1'b1;
                    mem_addr  = host_addr;
                    mem_wdata = host_data;
                end
            end
            RD_ISSUE: begin
                mem_addr  = fetch_row;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                mem_addr = fetch_row;
                if (wait_cnt == 2'd0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                mem_addr  = fetch_row;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A new line always restarts the sequencer; any read in flight is abandoned.
        if (line_start) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fetch_pend   <= 1'b0;
            fetch_row    <= '0;
            wait_cnt     <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            row_data     <= '0;
            row_valid    <= 1'b0;
            fetch_miss   <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_miss <= abort;

            case (state)
                RD_ISSUE: begin
                    fetch_pend <= 1'b0;
                    wait_cnt   <= WAIT_INIT;
                end
                RD_WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    if (!line_start) begin
                        shadow       <= capture_fmt(mem_rdata);
                        shadow_valid <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Promotion and new request registration override the FSM updates above.
            if (line_start) begin
                row_data     <= shadow;
                row_valid    <= shadow_valid && !abort;
                shadow_valid <= 1'b0;
                fetch_pend   <= ny_in_range;
                if (ny_in_range) begin
                    fetch_row <= ny_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_scheduler.sv
// Bench for sprite_mem_scheduler: directed steps then random lines/host traffic vs a line-level model.
module tb_sprite_mem_scheduler;

    localparam int ROWS      = 40;
    localparam int AW        = 6;
    localparam int DW        = 64;
    localparam int SPRITE_Y0 = 210;
    localparam int RD_LAT    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_start;
    logic [9:0]    cur_y;
    logic          host_valid;
    logic          host_ready;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] row_data;
    logic          row_valid;
    logic          fetch_miss;

    always #10 clk = ~clk;

    sprite_mem_scheduler #(
        .ROWS(ROWS), .AW(AW), .DW(DW), .SPRITE_Y0(SPRITE_Y0), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .cur_y(cur_y),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .row_data(row_data),
        .row_valid(row_valid), .fetch_miss(fetch_miss)
    );

    // Shared memory with RD_LAT cycles of read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] addr_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        addr_pipe[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign mem_rdata = mem[addr_pipe[RD_LAT-1]];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            busy_until = -1000;
    int            fetch_start = 1 << 30;
    logic [AW-1:0] fetch_row_m = '0;
    bit            req_inrange = 1'b0;
    logic [DW-1:0] req_data = '0;
    bit            exp_row_valid = 1'b0;
    logic [DW-1:0] exp_row_data = '0;
    bit            exp_miss = 1'b0;

`ifdef SPRITE_MIRROR_EN
    localparam logic [DW-1:0] ROW0_EXP = 64'h8000_0000_0000_0000;
`else
    localparam logic [DW-1:0] ROW0_EXP = 64'h1;
`endif

    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef SPRITE_MIRROR_EN
        for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit ls, input int y, input bit hv, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd);
        bit exp_ready;
        bit miss;
        int ny;
        @(negedge clk);
        line_start = ls;
        cur_y      = 10'(y);
        host_valid = hv;
        host_addr  = ha;
        host_data  = hd;
        #1;
        exp_ready = !ls && (cyc > busy_until);
        chk("host_ready", 64'(host_ready), 64'(exp_ready));
        if (hv && exp_ready) begin
            if (int'(ha) < ROWS) begin
                chk("wr_we", 64'(mem_we), 64'd1);
                chk("wr_addr", 64'(mem_addr), 64'(ha));
                chk("wr_data", mem_wdata, hd);
            end else begin
                chk("drop_we", 64'(mem_we), 64'd0);
            end
        end else begin
            chk("idle_we", 64'(mem_we), 64'd0);
            if (cyc >= fetch_start && cyc <= busy_until)
                chk("fetch_addr", 64'(mem_addr), 64'(fetch_row_m));
        end
        @(posedge clk);
        if (ls) begin
            miss          = (cyc <= busy_until);
            exp_miss      = miss;
            exp_row_valid = req_inrange && !miss;
            if (exp_row_valid) exp_row_data = req_data;
            ny = (y == 524) ? 1 : y + 1;
            req_inrange = (ny >= SPRITE_Y0) && (ny < SPRITE_Y0 + ROWS);
            if (req_inrange) begin
                fetch_row_m = AW'(ny - SPRITE_Y0);
                req_data    = fmt(mem[fetch_row_m]);
                fetch_start = cyc + 2;
                busy_until  = cyc + 3 + RD_LAT;
            end else begin
                fetch_start = 1 << 30;
                busy_until  = cyc;
            end
        end else begin
            exp_miss = 1'b0;
        end
        #1;
        chk("row_valid", 64'(row_valid), 64'(exp_row_valid));
        chk("fetch_miss", 64'(fetch_miss), 64'(exp_miss));
        if (exp_row_valid) chk("row_data", row_data, exp_row_data);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, '0, '0);
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        line_start = 1'b0;
        host_valid = 1'b0;
        rst        = 1'b0;
        #1;
        chk("rst_ready", 64'(host_ready), 64'd0);
        chk("rst_row_valid", 64'(row_valid), 64'd0);
        chk("rst_row_data", row_data, 64'd0);
        chk("rst_miss", 64'(fetch_miss), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        busy_until    = -1000;
        fetch_start   = 1 << 30;
        req_inrange   = 1'b0;
        exp_row_valid = 1'b0;
        exp_row_data  = '0;
        exp_miss      = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int  gap;
        bit  ls_r;
        int  y_r;
        rst        = 1'b0;
        line_start = 1'b0;
        cur_y      = '0;
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        reset_pulse(3);

        // Populate every row, including row 0 with a single set bit.
        step(1'b0, 0, 1'b1, 6'd0, 64'h1);
        for (int r = 1; r < 64; r++) step(1'b0, 0, 1'b1, AW'(r), {$urandom, $urandom});

        // Line before the sprite fetches row 0, shown on the next line.
        step(1'b1, 209, 1'b0, '0, '0);
        idle(12);
        step(1'b1, 210, 1'b0, '0, '0);
        chk("row0_fmt", row_data, ROW0_EXP);
        chk("row0_valid", 64'(row_valid), 64'd1);
        idle(12);

        // Host held valid across a line start: stalled, then resumes.
        step(1'b0, 0, 1'b1, 6'd5, 64'hA5);
        step(1'b1, 215, 1'b1, 6'd5, 64'hA5);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 6'd5, 64'hA5);

        // Last sprite row, then the first line past the sprite.
        step(1'b1, 248, 1'b0, '0, '0);
        idle(12);
        step(1'b1, 249, 1'b0, '0, '0);
        idle(12);
        step(1'b1, 250, 1'b0, '0, '0);
        chk("past_sprite", 64'(row_valid), 64'd0);
        idle(12);

        // Line start 3 clks after an in-range one aborts the prefetch.
        step(1'b1, 209, 1'b0, '0, '0);
        idle(2);
        step(1'b1, 210, 1'b0, '0, '0);
        chk("miss_pulse", 64'(fetch_miss), 64'd1);
        idle(12);
        step(1'b1, 211, 1'b0, '0, '0);
        idle(12);

        // Out-of-range address handshakes but never writes; frame wrap line.
        step(1'b0, 0, 1'b1, 6'd63, 64'hDEAD);
        step(1'b1, 524, 1'b0, '0, '0);
        idle(12);

        // Reset in the middle of a fetch.
        step(1'b1, 209, 1'b0, '0, '0);
        idle(2);
        reset_pulse(2);
        step(1'b1, 210, 1'b0, '0, '0);
        idle(12);
        step(1'b1, 211, 1'b0, '0, '0);
        chk("post_rst_valid", 64'(row_valid), 64'd1);
        idle(12);

        // Random lines (some too close together) with random host traffic.
        gap = 0;
        for (int k = 0; k < 1500; k++) begin
            ls_r = (gap == 0);
            if (ls_r) gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RD_LAT + 4)) - 1
                                                        : int'($urandom_range(8, 30)) - 1;
            else gap--;
            y_r = ($urandom_range(0, 9) == 0) ? 524 : int'($urandom_range(205, 255));
            step(ls_r, y_r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                 {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
